// File: rtl/md_pkg.sv
// Shared types and sizing helpers for the MD pair scheduler.
package md_pkg;
  localparam int MD_BLOCK_SIDE = 4;
  localparam int MD_DENSITY    = 10;
  localparam int MD_CNT_W      = 24;

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_DRAIN, ST_DONE} md_state_t;

  // Neighbour offset -1/0/+1
  typedef logic signed [1:0] md_off_t;
  localparam md_off_t OFF_NEG = 2'sb11;
  localparam md_off_t OFF_POS = 2'sb01;

  function automatic int md_addr_w(input int side, input int density);
    return $clog2(side * side * side * density);
  endfunction

  localparam int MD_ADDR_W = md_addr_w(MD_BLOCK_SIDE, MD_DENSITY);
endpackage

// File: rtl/md_pair_scheduler_if.sv
// Pair-issue and result-return handshake between the scheduler and the force pipeline.
interface md_pair_scheduler_if #(parameter int ADDR_W = md_pkg::MD_ADDR_W);
  logic              pair_valid;
  logic              pair_ready;
  logic [ADDR_W-1:0] pair_home_idx;
  logic [ADDR_W-1:0] pair_nbr_idx;
  logic              pair_last;
  logic              res_valid;

  modport master (
    output pair_valid, pair_home_idx, pair_nbr_idx, pair_last,
    input  pair_ready, res_valid
  );

  modport slave (
    input  pair_valid, pair_home_idx, pair_nbr_idx, pair_last,
    output pair_ready, res_valid
  );
endinterface

// File: rtl/md_wrap_coord.sv
// Periodic cell coordinate: (coord + off) mod BLOCK_SIDE for off in {-1,0,+1}.
module md_wrap_coord
  import md_pkg::*;
#(
  parameter int BLOCK_SIDE = MD_BLOCK_SIDE,
  parameter int COORD_W    = 2
) (
  input  logic [COORD_W-1:0] coord,
  input  md_off_t            off,
  output logic [COORD_W-1:0] wrapped
);
  localparam logic [COORD_W-1:0] C_MAX = COORD_W'(BLOCK_SIDE - 1);
  localparam logic [COORD_W-1:0] C_ONE = COORD_W'(1);

  always_comb begin
    wrapped = coord;
    if (off == OFF_NEG)
      wrapped = (coord == '0) ? C_MAX : coord - C_ONE;
    else if (off == OFF_POS)
      wrapped = (coord == C_MAX) ? '0 : coord + C_ONE;
  end
endmodule

// File: rtl/md_pair_scheduler.sv
// Walks home atoms x 27 periodic neighbour cells x neighbour slots and issues
// credit-limited (home,nbr) pairs to the force pipeline for one sweep.
//
// state    | meaning
// ST_IDLE  | waiting for start, results ignored
// ST_ISSUE | walking the loop nest and offering pairs
// ST_DRAIN | all pairs accepted, waiting for outstanding results
// ST_DONE  | sweep complete, done held until next start
module md_pair_scheduler
  import md_pkg::*;
#(
  parameter int BLOCK_SIDE = MD_BLOCK_SIDE,
  parameter int DENSITY    = MD_DENSITY,
  parameter int MAX_OUT    = 8,
  parameter int ADDR_W     = md_addr_w(BLOCK_SIDE, DENSITY),
  parameter int CNT_W      = MD_CNT_W
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  md_pair_scheduler_if.master  pipe,
  output logic [CNT_W-1:0]     pairs_issued,
  output logic                 proto_err
);
  localparam int COORD_W = $clog2(BLOCK_SIDE);
  localparam int SLOT_W  = (DENSITY > 1) ? $clog2(DENSITY) : 1;
  localparam logic [COORD_W-1:0] C_MAX   = COORD_W'(BLOCK_SIDE - 1);
  localparam logic [COORD_W-1:0] C_ONE   = COORD_W'(1);
  localparam logic [SLOT_W-1:0]  S_MAX   = SLOT_W'(DENSITY - 1);
  localparam logic [SLOT_W-1:0]  S_ONE   = SLOT_W'(1);
  localparam logic [7:0]         OUT_LIM = 8'(MAX_OUT);

  md_state_t state, state_nxt;
  logic [COORD_W-1:0] cx, cy, cz, nx, ny, nz;
  logic [SLOT_W-1:0]  hs, ns;
  md_off_t            dx, dy, dz;
  logic               all_loaded;
  logic [7:0]         outstanding, out_nxt;
  logic               accept, res_take, cand_self, cand_last, step, load, active;
  logic               c_ns, c_dx, c_dy, c_dz, c_hs, c_cx, c_cy;
  logic [ADDR_W-1:0]  home_addr, nbr_addr;

  md_wrap_coord #(.BLOCK_SIDE(BLOCK_SIDE), .COORD_W(COORD_W)) u_wrap_x (.coord(cx), .off(dx), .wrapped(nx));
  md_wrap_coord #(.BLOCK_SIDE(BLOCK_SIDE), .COORD_W(COORD_W)) u_wrap_y (.coord(cy), .off(dy), .wrapped(ny));
  md_wrap_coord #(.BLOCK_SIDE(BLOCK_SIDE), .COORD_W(COORD_W)) u_wrap_z (.coord(cz), .off(dz), .wrapped(nz));

  function automatic logic [ADDR_W-1:0] atom_addr(input logic [COORD_W-1:0] x, y, z,
                                                  input logic [SLOT_W-1:0] slot);
    return ADDR_W'(((int'(z) * BLOCK_SIDE + int'(y)) * BLOCK_SIDE + int'(x)) * DENSITY + int'(slot));
  endfunction

  always_comb begin
    active    = (state == ST_ISSUE) || (state == ST_DRAIN);
    accept    = pipe.pair_valid && pipe.pair_ready;
    res_take  = pipe.res_valid && active && (outstanding != '0);
    out_nxt   = outstanding + 8'(accept) - 8'(res_take);
    home_addr = atom_addr(cx, cy, cz, hs);
    nbr_addr  = atom_addr(nx, ny, nz, ns);
    cand_self = (home_addr == nbr_addr);
    c_ns      = (ns == S_MAX);
    c_dx      = c_ns && (dx == OFF_POS);
    c_dy      = c_dx && (dy == OFF_POS);
    c_dz      = c_dy && (dz == OFF_POS);
    c_hs      = c_dz && (hs == S_MAX);
    c_cx      = c_hs && (cx == C_MAX);
    c_cy      = c_cx && (cy == C_MAX);
    cand_last = c_cy && (cz == C_MAX);
    // Self pairs advance without needing a credit; real pairs need one after this cycle's traffic.
    step      = (state == ST_ISSUE) && !all_loaded && (!pipe.pair_valid || accept)
                && (cand_self || (out_nxt < OUT_LIM));
    load      = step && !cand_self;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE, ST_DONE: if (start) state_nxt = ST_ISSUE;
      ST_ISSUE:         if (accept && all_loaded) state_nxt = ST_DRAIN;
      ST_DRAIN:         if (outstanding == '0) state_nxt = ST_DONE;
      default:          state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  assign busy = active;
  assign done = (state == ST_DONE);

  always_ff @(posedge clk) begin
    if (!reset) begin
      {cx, cy, cz}        <= '0;
      {hs, ns}            <= '0;
      {dx, dy, dz}        <= '0;
      all_loaded          <= 1'b0;
      outstanding         <= '0;
      pairs_issued        <= '0;
      proto_err           <= 1'b0;
      pipe.pair_valid     <= 1'b0;
      pipe.pair_last      <= 1'b0;
      pipe.pair_home_idx  <= '0;
      pipe.pair_nbr_idx   <= '0;
    end else if ((state == ST_IDLE || state == ST_DONE) && start) begin
      {cx, cy, cz}        <= '0;
      {hs, ns}            <= '0;
      dx                  <= OFF_NEG;
      dy                  <= OFF_NEG;
      dz                  <= OFF_NEG;
      all_loaded          <= 1'b0;
      outstanding         <= '0;
      pairs_issued        <= '0;
      proto_err           <= 1'b0;
      pipe.pair_valid     <= 1'b0;
      pipe.pair_last      <= 1'b0;
    end else begin
      if (active) begin
        outstanding <= out_nxt;
        if (pipe.res_valid && outstanding == '0) proto_err <= 1'b1;
      end
      if (accept) begin
        pipe.pair_valid <= 1'b0;
        pipe.pair_last  <= 1'b0;
        if (pairs_issued != '1) pairs_issued <= pairs_issued + CNT_W'(1);
      end
      if (load) begin
        pipe.pair_valid    <= 1'b1;
        pipe.pair_home_idx <= home_addr;
        pipe.pair_nbr_idx  <= nbr_addr;
        pipe.pair_last     <= c_dz;
      end
      if (step) begin
        ns <= c_ns ? '0 : ns + S_ONE;
        if (c_ns) dx <= c_dx ? OFF_NEG : md_off_t'(dx + OFF_POS);
        if (c_dx) dy <= c_dy ? OFF_NEG : md_off_t'(dy + OFF_POS);
        if (c_dy) dz <= c_dz ? OFF_NEG : md_off_t'(dz + OFF_POS);
        if (c_dz) hs <= c_hs ? '0 : hs + S_ONE;
        if (c_hs) cx <= c_cx ? '0 : cx + C_ONE;
        if (c_cx) cy <= c_cy ? '0 : cy + C_ONE;
        if (c_cy) cz <= cand_last ? '0 : cz + C_ONE;
        if (cand_last) all_loaded <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_md_pair_scheduler.sv
// Self-checking bench: full sweeps against a loop-nest pair model, stall/reset and protocol-error cases.
module tb_md_pair_scheduler;
  localparam int S     = 3;
  localparam int D     = 2;
  localparam int MO    = 4;
  localparam int AW    = 6;
  localparam int CW    = 24;
  localparam int TOTAL = S * S * S * D * (27 * D - 1);

  logic          clk = 1'b0;
  logic          reset, start;
  logic          busy, done, proto_err;
  logic [CW-1:0] pairs_issued;

  md_pair_scheduler_if #(.ADDR_W(AW)) pif ();

  md_pair_scheduler #(
    .BLOCK_SIDE(S), .DENSITY(D), .MAX_OUT(MO), .ADDR_W(AW), .CNT_W(CW)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
    .pipe(pif), .pairs_issued(pairs_issued), .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  typedef struct {int home; int nbr; bit last;} pair_t;
  typedef struct {int acc_no; int home; int nbr; bit last;} vec_t;

  pair_t exp_q[$];
  pair_t got[$];
  vec_t  tbl[$];
  int    n_vec = 0;
  int    n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Expected pair stream straight from the loop-nest description.
  function automatic void build_model();
    int home, nbr;
    exp_q.delete();
    for (int z = 0; z < S; z++)
      for (int y = 0; y < S; y++)
        for (int x = 0; x < S; x++)
          for (int h = 0; h < D; h++)
            for (int dz = -1; dz <= 1; dz++)
              for (int dy = -1; dy <= 1; dy++)
                for (int dx = -1; dx <= 1; dx++)
                  for (int n = 0; n < D; n++) begin
                    home = ((z * S + y) * S + x) * D + h;
                    nbr  = ((((z + dz + S) % S) * S + ((y + dy + S) % S)) * S + ((x + dx + S) % S)) * D + n;
                    if (nbr != home)
                      exp_q.push_back('{home, nbr, (dz == 1 && dy == 1 && dx == 1 && n == D - 1)});
                  end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_sweep(input bit rnd, input bit inject, input int budget);
    int   cyc, n_acc, outm, selfs;
    int   due_q[$];
    bit   acc, hold, res, injected;
    logic [AW-1:0] ph, pn;
    logic pl;
    pair_t e;
    build_model();
    got.delete();
    start = 1'b1;
    tick();
    start = 1'b0;
    check("start_clears_issued", pairs_issued, 0);
    check("start_busy", busy, 1);
    check("start_clears_proto_err", proto_err, 0);
    check("start_clears_done", done, 0);
    cyc = 0; n_acc = 0; outm = 0; injected = 0;
    while (!done && cyc < budget) begin
      pif.pair_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      start = rnd ? ($urandom_range(0, 15) == 0) : 1'b0;
      res = 1'b0;
      if (due_q.size() > 0 && due_q[0] <= cyc) begin
        res = 1'b1;
        void'(due_q.pop_front());
        outm--;
      end else if (inject && !injected && outm == 0 && n_acc == TOTAL && busy) begin
        res = 1'b1;
        injected = 1'b1;
      end
      pif.res_valid = res;
      acc  = pif.pair_valid && pif.pair_ready;
      hold = pif.pair_valid && !pif.pair_ready;
      ph = pif.pair_home_idx; pn = pif.pair_nbr_idx; pl = pif.pair_last;
      tick();
      cyc++;
      if (acc) begin
        got.push_back('{int'(ph), int'(pn), pl});
        if (exp_q.size() == 0) check("pair_count_overrun", n_acc + 1, TOTAL);
        else begin
          e = exp_q.pop_front();
          check("pair_home", ph, e.home);
          check("pair_nbr", pn, e.nbr);
          check("pair_last", pl, e.last);
        end
        n_acc++;
        outm++;
        check("outstanding_le_max", outm <= MO, 1);
        due_q.push_back(cyc + (rnd ? int'($urandom_range(0, 5)) : 2));
      end
      if (hold) begin
        check("hold_valid", pif.pair_valid, 1);
        check("hold_home", pif.pair_home_idx, ph);
        check("hold_nbr", pif.pair_nbr_idx, pn);
        check("hold_last", pif.pair_last, pl);
      end
    end
    start = 1'b0;
    pif.res_valid = 1'b0;
    check("sweep_done", done, 1);
    check("sweep_busy_low", busy, 0);
    check("pairs_accepted", n_acc, TOTAL);
    check("pairs_issued", pairs_issued, TOTAL);
    check("model_consumed", exp_q.size(), 0);
    check("results_returned", outm, 0);
    check("proto_err_end", proto_err, inject);
    selfs = 0;
    foreach (got[i]) if (got[i].home == got[i].nbr) selfs++;
    check("no_self_pairs", selfs, 0);
    foreach (tbl[i]) begin
      if (tbl[i].acc_no >= got.size()) check("table_missing_pair", got.size(), tbl[i].acc_no + 1);
      else begin
        check("table_home", got[tbl[i].acc_no].home, tbl[i].home);
        check("table_nbr", got[tbl[i].acc_no].nbr, tbl[i].nbr);
        check("table_last", got[tbl[i].acc_no].last, tbl[i].last);
      end
    end
    repeat (3) tick();
    check("done_held", done, 1);
    check("issued_held", pairs_issued, TOTAL);
    check("proto_err_sticky", proto_err, inject);
  endtask

  task automatic stall_and_reset();
    int n_acc;
    bit acc;
    logic [AW-1:0] ph, pn;
    pif.pair_ready = 1'b1;
    pif.res_valid  = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    n_acc = 0;
    repeat (40) begin
      acc = pif.pair_valid && pif.pair_ready;
      tick();
      if (acc) n_acc++;
    end
    check("stall_accepts", n_acc, MO);
    check("stall_busy", busy, 1);
    check("stall_done_low", done, 0);
    check("stall_issued", pairs_issued, MO);
    check("stall_last_home", pif.pair_home_idx, 0);
    check("stall_last_nbr", pif.pair_nbr_idx, 49);
    ph = pif.pair_home_idx; pn = pif.pair_nbr_idx; n_acc = 0;
    repeat (5) begin
      acc = pif.pair_valid && pif.pair_ready;
      tick();
      if (acc) n_acc++;
    end
    check("stall_no_more_accepts", n_acc, 0);
    check("stall_home_stable", pif.pair_home_idx, ph);
    check("stall_nbr_stable", pif.pair_nbr_idx, pn);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    check("mid_reset_busy", busy, 0);
    check("mid_reset_done", done, 0);
    check("mid_reset_valid", pif.pair_valid, 0);
    check("mid_reset_last", pif.pair_last, 0);
    check("mid_reset_home", pif.pair_home_idx, 0);
    check("mid_reset_nbr", pif.pair_nbr_idx, 0);
    check("mid_reset_issued", pairs_issued, 0);
    check("mid_reset_proto", proto_err, 0);
    pif.res_valid = 1'b1;
    repeat (3) tick();
    pif.res_valid = 1'b0;
    tick();
    check("idle_res_no_proto", proto_err, 0);
    check("idle_res_busy", busy, 0);
    check("idle_res_done", done, 0);
    check("idle_res_valid", pif.pair_valid, 0);
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl = '{
      '{0, 0, 52, 1'b0}, '{1, 0, 53, 1'b0}, '{2, 0, 48, 1'b0}, '{3, 0, 49, 1'b0},
      '{4, 0, 50, 1'b0}, '{25, 0, 5, 1'b0}, '{26, 0, 1, 1'b0}, '{52, 0, 27, 1'b1},
      '{53, 1, 52, 1'b0}, '{105, 1, 27, 1'b1}, '{TOTAL - 1, 53, 1, 1'b1}
    };
    reset = 1'b0;
    start = 1'b0;
    pif.pair_ready = 1'b0;
    pif.res_valid  = 1'b0;
    repeat (3) tick();
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_valid", pif.pair_valid, 0);
    check("reset_last", pif.pair_last, 0);
    check("reset_home", pif.pair_home_idx, 0);
    check("reset_nbr", pif.pair_nbr_idx, 0);
    check("reset_issued", pairs_issued, 0);
    check("reset_proto", proto_err, 0);
    reset = 1'b1;
    tick();
    run_sweep(1'b0, 1'b0, 20000);
    stall_and_reset();
    run_sweep(1'b0, 1'b0, 20000);
    run_sweep(1'b1, 1'b1, 40000);
    run_sweep(1'b0, 1'b0, 20000);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
